// File: rtl/tty_uart_rx.sv
// 8N1 serial receiver: synchronises the pad, samples each bit at its midpoint and
// emits the byte with a one-cycle strobe, or a one-cycle frame_err if the stop bit reads low.
module tty_uart_rx #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 230400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pad,
  output logic [7:0] data,
  output logic       strobe,
  output logic       frame_err
);

  localparam int DIV  = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          pad_meta_q, pad_s_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitn_q, bitn_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          strobe_q, strobe_d;
  logic          ferr_q, ferr_d;
  logic          tick;

  assign tick      = (cnt_q == '0);
  assign data      = data_q;
  assign strobe    = strobe_q;
  assign frame_err = ferr_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitn_d   = bitn_q;
    sh_d     = sh_q;
    data_d   = data_q;
    strobe_d = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!pad_s_q) begin
          state_d = S_START;
          cnt_d   = CW'(HALF - 1);
        end
      end
      S_START: begin
        if (tick) begin
          // A start bit that has gone high again by mid-bit was only a glitch.
          if (!pad_s_q) begin
            state_d = S_DATA;
            cnt_d   = CW'(DIV - 1);
            bitn_d  = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          sh_d   = {pad_s_q, sh_q[7:1]};
          bitn_d = bitn_q + 3'd1;
          cnt_d  = CW'(DIV - 1);
          if (bitn_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          if (pad_s_q) begin
            data_d   = sh_q;
            strobe_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BREAK: begin
        // A line held low must return high before a new start bit is accepted.
        if (pad_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pad_meta_q <= 1'b1;
      pad_s_q    <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bitn_q     <= 3'd0;
      sh_q       <= 8'h00;
      data_q     <= 8'h00;
      strobe_q   <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      pad_meta_q <= pad;
      pad_s_q    <= pad_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitn_q     <= bitn_d;
      sh_q       <= sh_d;
      data_q     <= data_d;
      strobe_q   <= strobe_d;
      ferr_q     <= ferr_d;
    end
  end

endmodule

// File: tb/tb_tty_uart_rx.sv
// Directed bench for tty_uart_rx: frames driven on pad at nominal and skewed baud,
// strobes and frame errors collected by a monitor and compared against hand-computed values.
module tb_tty_uart_rx;

  localparam int BT      = 434;
  localparam int HALF    = 217;
  localparam int LATENCY = 2 + HALF + 9 * BT + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pad = 1'b1;
  logic [7:0] data;
  logic       strobe;
  logic       frame_err;

  int unsigned cyc = 0;
  int unsigned frame_start_cyc = 0;
  int unsigned last_strobe_cyc = 0;
  int          strobe_cnt = 0;
  int          ferr_cnt = 0;
  int          both_cnt = 0;
  int          wide_cnt = 0;
  logic [7:0]  rxq[$];
  logic        prev_pulse = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  tty_uart_rx #(.CLK_FREQ(100000000), .BAUD_RATE(230400)) dut (
    .clk      (clk),
    .rst      (rst),
    .pad      (pad),
    .data     (data),
    .strobe   (strobe),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (strobe) begin
      strobe_cnt      <= strobe_cnt + 1;
      last_strobe_cyc <= cyc;
      rxq.push_back(data);
    end
    if (frame_err)           ferr_cnt <= ferr_cnt + 1;
    if (strobe && frame_err) both_cnt <= both_cnt + 1;
    if ((strobe || frame_err) && prev_pulse) wide_cnt <= wide_cnt + 1;
    prev_pulse <= strobe || frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb, input int bt);
    @(negedge clk);
    pad = 1'b0;
    frame_start_cyc = cyc;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      pad = b[i];
      repeat (bt) @(negedge clk);
    end
    pad = stopb;
    repeat (bt - 1) @(negedge clk);
  endtask

  function automatic logic [7:0] pop_byte();
    if (rxq.size() == 0) return 8'hxx;
    return rxq.pop_front();
  endfunction

  int base;

  initial begin
    idle(5);
    rst = 1'b0;
    idle(2);
    chk("reset_data", {24'h0, data}, 32'h00);
    chk("reset_strobe", {31'h0, strobe}, 32'h0);
    chk("reset_ferr", {31'h0, frame_err}, 32'h0);

    // 1: nominal frame and its latency
    idle(20);
    send_frame(8'h55, 1'b1, BT);
    pad = 1'b1;
    idle(50);
    chk("t1_count", strobe_cnt, 1);
    chk("t1_data", {24'h0, pop_byte()}, 32'h55);
    chk("t1_latency", last_strobe_cyc - frame_start_cyc, LATENCY);
    chk("t1_ferr", ferr_cnt, 0);

    // 2: short low glitch is rejected
    base = strobe_cnt;
    @(negedge clk);
    pad = 1'b0;
    idle(100);
    pad = 1'b1;
    idle(400);
    chk("t2_glitch_strobe", strobe_cnt - base, 0);
    chk("t2_glitch_ferr", ferr_cnt, 0);
    send_frame(8'hA5, 1'b1, BT);
    pad = 1'b1;
    idle(50);
    chk("t2_count", strobe_cnt - base, 1);
    chk("t2_data", {24'h0, pop_byte()}, 32'hA5);

    // 3: stop bit low, line held low, then released
    base = strobe_cnt;
    send_frame(8'h3C, 1'b0, BT);
    idle(2 * BT);
    pad = 1'b1;
    idle(50);
    chk("t3_ferr", ferr_cnt, 1);
    chk("t3_no_strobe", strobe_cnt - base, 0);
    chk("t3_data_held", {24'h0, data}, 32'hA5);
    send_frame(8'h81, 1'b1, BT);
    pad = 1'b1;
    idle(50);
    chk("t3_count", strobe_cnt - base, 1);
    chk("t3_data", {24'h0, pop_byte()}, 32'h81);

    // 4: back-to-back frames with no idle gap
    base = strobe_cnt;
    send_frame(8'h00, 1'b1, BT);
    send_frame(8'hFF, 1'b1, BT);
    send_frame(8'h7E, 1'b1, BT);
    pad = 1'b1;
    idle(50);
    chk("t4_count", strobe_cnt - base, 3);
    chk("t4_data0", {24'h0, pop_byte()}, 32'h00);
    chk("t4_data1", {24'h0, pop_byte()}, 32'hFF);
    chk("t4_data2", {24'h0, pop_byte()}, 32'h7E);

    // 5: reset during data bit 4 of an F0 frame (remaining bits are high)
    base = strobe_cnt;
    @(negedge clk);
    pad = 1'b0;
    repeat (BT) @(negedge clk);
    pad = 1'b0;
    repeat (4 * BT) @(negedge clk);
    pad = 1'b1;
    repeat (BT / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(5 * BT);
    chk("t5_no_strobe", strobe_cnt - base, 0);
    chk("t5_data_cleared", {24'h0, data}, 32'h00);
    send_frame(8'hC3, 1'b1, BT);
    pad = 1'b1;
    idle(50);
    chk("t5_count", strobe_cnt - base, 1);
    chk("t5_data", {24'h0, pop_byte()}, 32'hC3);

    // 6: baud mismatch, fast then slow
    base = strobe_cnt;
    send_frame(8'h96, 1'b1, 421);
    pad = 1'b1;
    idle(100);
    chk("t6_fast_data", {24'h0, pop_byte()}, 32'h96);
    send_frame(8'h96, 1'b1, 447);
    pad = 1'b1;
    idle(100);
    chk("t6_slow_data", {24'h0, pop_byte()}, 32'h96);
    chk("t6_count", strobe_cnt - base, 2);

    chk("ferr_total", ferr_cnt, 1);
    chk("no_overlap", both_cnt, 0);
    chk("one_cycle_pulses", wide_cnt, 0);
    chk("no_extra_bytes", rxq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
